// File: rtl/lbm_lattice_mem.sv
// Double-buffered D2Q9 population store with streaming on write and self-init after reset.
// Define LBM_BOUNCEBACK_EN to reflect populations of solid cells in place instead of streaming them.
module lbm_lattice_mem #(
    parameter int               NX         = 50,
    parameter int               NY         = 50,
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] W0_INIT    = 16'h0E38,
    parameter logic [WIDTH-1:0] WAX_INIT   = 16'h038E,
    parameter logic [WIDTH-1:0] WDIAG_INIT = 16'h00E4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   rd_req,
    input  logic [$clog2(NX)-1:0]  rd_x,
    input  logic [$clog2(NY)-1:0]  rd_y,
    output logic                   rd_valid,
    output logic [9*WIDTH-1:0]     rd_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [$clog2(NX)-1:0]  wr_x,
    input  logic [$clog2(NY)-1:0]  wr_y,
    input  logic [9*WIDTH-1:0]     wr_data,
    input  logic                   wr_solid,
    input  logic                   swap_req,
    output logic                   swap_done,
    output logic                   bank_sel,
    output logic [31:0]            step_cnt
);
    localparam int XW    = $clog2(NX);
    localparam int YW    = $clog2(NY);
    localparam int CELLS = NX * NY;
    localparam int AW    = $clog2(CELLS);

    typedef enum logic [1:0] {INIT, RUN, SWAP} state_t;

    function automatic int dir_dx(int d);
        case (d)
            2, 3, 4: return 1;
            6, 7, 8: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int dir_dy(int d);
        case (d)
            1, 2, 8: return 1;
            4, 5, 6: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int dir_opp(int d);
        return (d == 0) ? 0 : ((d + 3) % 8) + 1;
    endfunction

    function automatic logic [WIDTH-1:0] init_val(int d);
        if (d == 0)     return W0_INIT;
        if (d % 2 == 1) return WAX_INIT;
        return WDIAG_INIT;
    endfunction

    function automatic logic [AW-1:0] addr_of(logic [XW-1:0] x, logic [YW-1:0] y);
        return AW'(int'(y) * NX + int'(x));
    endfunction

    logic [WIDTH-1:0] mem [2][9][CELLS];

    state_t                    state, state_d;
    logic [AW-1:0]             init_cnt;
    logic                      swap_fire, armed;
    logic                      s1_vld;
    logic [8:0][AW-1:0]        s1_addr, dst_addr;
    logic [8:0][WIDTH-1:0]     s1_data, dst_data;
    logic [9*WIDTH-1:0]        rd_word;
    logic                      accept, wr_in_range, rd_in_range, rd_fire, bounce;
    logic [XW-1:0]             xp, xm;
    logic [YW-1:0]             yp, ym;

    always_comb begin
        state_d   = state;
        swap_fire = 1'b0;
        ready     = (state != INIT);
        wr_ready  = (state == RUN) && !swap_req;
        case (state)
            INIT: if (init_cnt == AW'(CELLS - 1)) state_d = RUN;
            RUN:  if (swap_req && armed) state_d = SWAP;
            // stage-2 write still in flight would land in the wrong bank after the toggle
            SWAP: if (!s1_vld) begin
                swap_fire = 1'b1;
                state_d   = RUN;
            end
            default: state_d = INIT;
        endcase
    end

`ifdef LBM_BOUNCEBACK_EN
    assign bounce = wr_solid;
`else
    assign bounce = wr_solid & 1'b0;  // solid cells stream like fluid
`endif

    assign wr_in_range = (int'(wr_x) < NX) && (int'(wr_y) < NY);
    assign rd_in_range = (int'(rd_x) < NX) && (int'(rd_y) < NY);
    assign accept      = wr_valid && wr_ready;
    assign rd_fire     = rd_req && (state == RUN);

    // periodic neighbours by compare/select
    assign xp = (int'(wr_x) >= NX - 1) ? '0 : wr_x + XW'(1);
    assign xm = (wr_x == '0) ? XW'(NX - 1) : wr_x - XW'(1);
    assign yp = (int'(wr_y) >= NY - 1) ? '0 : wr_y + YW'(1);
    assign ym = (wr_y == '0) ? YW'(NY - 1) : wr_y - YW'(1);

    for (genvar d = 0; d < 9; d++) begin : g_dir
        localparam int EX  = dir_dx(d);
        localparam int EY  = dir_dy(d);
        localparam int OPP = dir_opp(d);
        logic [XW-1:0] dst_x;
        logic [YW-1:0] dst_y;
        assign dst_x = (EX > 0) ? xp : (EX < 0) ? xm : wr_x;
        assign dst_y = (EY > 0) ? yp : (EY < 0) ? ym : wr_y;
        // array d of the source cell receives the reflected population opp(d)
        assign dst_addr[d] = bounce ? addr_of(wr_x, wr_y) : addr_of(dst_x, dst_y);
        assign dst_data[d] = bounce ? wr_data[OPP*WIDTH +: WIDTH] : wr_data[d*WIDTH +: WIDTH];
        assign rd_word[d*WIDTH +: WIDTH] = mem[bank_sel][d][addr_of(rd_x, rd_y)];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            init_cnt  <= '0;
            armed     <= 1'b1;
            s1_vld    <= 1'b0;
            s1_addr   <= '0;
            s1_data   <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            swap_done <= 1'b0;
            bank_sel  <= 1'b0;
            step_cnt  <= '0;
        end else begin
            state     <= state_d;
            init_cnt  <= (state == INIT) ? init_cnt + AW'(1) : '0;
            s1_vld    <= accept && wr_in_range;
            if (accept) begin
                s1_addr <= dst_addr;
                s1_data <= dst_data;
            end
            rd_valid  <= rd_fire;
            if (rd_fire) rd_data <= rd_in_range ? rd_word : '0;
            swap_done <= swap_fire;
            if (swap_fire) begin
                bank_sel <= ~bank_sel;
                step_cnt <= step_cnt + 32'd1;
                armed    <= 1'b0;
            end else if (!swap_req) begin
                armed    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int d = 0; d < 9; d++) begin
                mem[0][d][init_cnt] <= init_val(d);
                mem[1][d][init_cnt] <= init_val(d);
            end
        end else if (s1_vld) begin
            for (int d = 0; d < 9; d++) mem[~bank_sel][d][s1_addr[d]] <= s1_data[d];
        end
    end
endmodule

// File: tb/tb_lbm_lattice_mem.sv
// Directed bench for lbm_lattice_mem: init values, wrap-around streaming, swap handshake, reset.
module tb_lbm_lattice_mem;
    localparam int NX = 50;
    localparam int NY = 50;
    localparam int W  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ready, rd_req, rd_valid, wr_valid, wr_ready, wr_solid;
    logic           swap_req, swap_done, bank_sel;
    logic [5:0]     rd_x, rd_y, wr_x, wr_y;
    logic [9*W-1:0] rd_data, wr_data;
    logic [31:0]    step_cnt;

    int checks = 0;
    int failures = 0;
    int exp_steps = 0;
    logic exp_bank = 1'b0;

    always #5 clk = ~clk;

    lbm_lattice_mem #(.NX(NX), .NY(NY), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .wr_solid(wr_solid),
        .swap_req(swap_req), .swap_done(swap_done), .bank_sel(bank_sel), .step_cnt(step_cnt)
    );

    task automatic check(input string tag, input logic [9*W-1:0] obs, input logic [9*W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*W-1:0] init_vec();
        logic [9*W-1:0] v;
        for (int d = 0; d < 9; d++)
            v[d*W +: W] = (d == 0) ? 16'h0E38 : (d % 2 == 1) ? 16'h038E : 16'h00E4;
        return v;
    endfunction

    task automatic rd(input int x, input int y, output logic [9*W-1:0] data, output logic vld);
        @(negedge clk);
        rd_req = 1'b1; rd_x = 6'(x); rd_y = 6'(y);
        @(negedge clk);
        rd_req = 1'b0;
        data = rd_data; vld = rd_valid;
    endtask

    task automatic chk_dir(input string tag, input int x, input int y, input int d, input logic [W-1:0] exp);
        logic [9*W-1:0] data;
        logic           vld;
        logic [W-1:0]   f;
        rd(x, y, data, vld);
        f = data[d*W +: W];
        check(tag, vld ? f : 16'hxxxx, exp);
    endtask

    task automatic wr(input int x, input int y, input logic [9*W-1:0] data, input logic solid);
        @(negedge clk);
        wr_valid = 1'b1; wr_x = 6'(x); wr_y = 6'(y); wr_data = data; wr_solid = solid;
        @(negedge clk);
        wr_valid = 1'b0; wr_solid = 1'b0;
    endtask

    // swap_req held for 6 cycles; a write is offered at (5,5) throughout
    task automatic do_swap(input string tag);
        int pulses = 0;
        int lat = 0;
        logic [9*W-1:0] junk = '0;
        junk[W-1:0] = 16'hBEEF;
        @(negedge clk);
        swap_req = 1'b1;
        wr_valid = 1'b1; wr_x = 6'd5; wr_y = 6'd5; wr_data = junk;
        #1 check({tag, "_wr_ready"}, wr_ready, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (swap_done) begin
                pulses++;
                if (lat == 0) lat = c;
            end
        end
        swap_req = 1'b0; wr_valid = 1'b0;
        exp_steps++;
        exp_bank = ~exp_bank;
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_latency_le3"}, (lat >= 1 && lat <= 3), 1'b1);
        @(negedge clk);
        check({tag, "_bank_sel"}, bank_sel, exp_bank);
        check({tag, "_step_cnt"}, step_cnt, exp_steps);
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!ready && cyc < 3000) begin
            @(posedge clk);
            #1 cyc++;
        end
        check(tag, cyc, NX * NY);
        @(negedge clk);
    endtask

    initial begin
        logic [9*W-1:0] v, data;
        logic           vld;

        rd_req = 0; rd_x = 0; rd_y = 0;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_data = '0; wr_solid = 0;
        swap_req = 0;

        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, '0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_swap_done", swap_done, 1'b0);
        check("rst_bank_sel", bank_sel, 1'b0);
        check("rst_step_cnt", step_cnt, 0);
        rst = 1'b1;
        wait_ready("ready_latency");
        check("run_wr_ready", wr_ready, 1'b1);

        rd(0, 0, data, vld);
        check("init_valid", vld, 1'b1);
        check("init_cell00", data, init_vec());

        // back-to-back reads: out-of-range then in-range
        @(negedge clk);
        rd_req = 1; rd_x = 6'd60; rd_y = 6'd0;
        @(negedge clk);
        check("oob_valid", rd_valid, 1'b1);
        check("oob_data", rd_data, '0);
        rd_x = 6'd0; rd_y = 6'd0;
        @(negedge clk);
        rd_req = 0;
        check("b2b_valid", rd_valid, 1'b1);
        check("b2b_data", rd_data, init_vec());

        // E wrap on x
        v = '0; v[3*W +: W] = 16'h1234;
        wr(49, 10, v, 1'b0);
        do_swap("swap1");
        chk_dir("e_wrap", 0, 10, 3, 16'h1234);
        chk_dir("e_src_untouched", 49, 10, 3, 16'h038E);
        chk_dir("swap_blocked_write", 5, 5, 0, 16'h0E38);

        // NE corner wrap, plus every direction from the origin
        v = '0; v[2*W +: W] = 16'h0ABC;
        wr(5, 49, v, 1'b0);
        for (int d = 0; d < 9; d++) v[d*W +: W] = 16'(16'h1000 + d * 16'h0111);
        wr(0, 0, v, 1'b0);
        do_swap("swap2");
        chk_dir("ne_corner", 6, 0, 2, 16'h0ABC);
        chk_dir("org_rest", 0, 0, 0, 16'h1000);
        chk_dir("org_n", 0, 1, 1, 16'h1111);
        chk_dir("org_ne", 1, 1, 2, 16'h1222);
        chk_dir("org_se", 1, 49, 4, 16'h1444);
        chk_dir("org_sw", 49, 49, 6, 16'h1666);
        chk_dir("org_w", 49, 0, 7, 16'h1777);
        chk_dir("org_nw", 49, 1, 8, 16'h1888);

        v = '0; v[1*W +: W] = 16'h0111;
        wr(20, 20, v, 1'b1);
        do_swap("swap3");
`ifdef LBM_BOUNCEBACK_EN
        chk_dir("bb_reflect", 20, 20, 5, 16'h0111);
        chk_dir("bb_neighbour", 20, 21, 1, 16'h038E);
`else
        chk_dir("solid_streams", 20, 21, 1, 16'h0111);
        chk_dir("solid_src", 20, 20, 5, 16'h038E);
`endif

        // reset during RUN
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rerst_step_cnt", step_cnt, 0);
        check("rerst_bank_sel", bank_sel, 1'b0);
        check("rerst_ready", ready, 1'b0);
        check("rerst_rd_valid", rd_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_ready("ready_latency2");
        rd(6, 0, data, vld);
        check("reinit_cell60", data, init_vec());
        rd(0, 10, data, vld);
        check("reinit_cell010", data, init_vec());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
